// File: rtl/cla_pipe_addsub.sv
// ---------------------------------------------------------------------------
// cla_pipe_addsub
//
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready
// handshakes on the operand side and the result side. It sustains one
// operation per cycle and holds up to two beats (one per stage).
//
// Stage 1 forms the per-bit generate/propagate terms, the 4-bit group G/P
// terms and the carry-in, and registers them. Stage 2 resolves the group
// carries by lookahead, forms the bit carries inside each group, and
// registers the sum together with its carry-out, signed-overflow and zero flags.
//
// Parameters
//   WIDTH      operand/result width, a multiple of 4 (minimum 4)
//
// Ports
//   clock      rising-edge clock
//   reset      synchronous active-high reset
//   in_valid   operand beat valid
//   in_ready   block accepts a beat this cycle (combinational)
//   a, b       operands
//   ci         carry-in, add mode only
//   op         0: a + b + ci, 1: a - b (a + ~b + 1, ci ignored)
//   out_valid  result beat valid (registered)
//   out_ready  consumer accepts the result this cycle
//   s          sum / difference
//   co         carry out of the MSB (subtract: 1 means no borrow)
//   ovf        signed overflow (carry into MSB xor carry out of MSB)
//   zero       s == 0
// ---------------------------------------------------------------------------
module cla_pipe_addsub #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf,
  output logic             zero
);

  localparam int NG = WIDTH / 4;

  // -------------------------------------------------------------------------
  // Handshake
  // -------------------------------------------------------------------------
  logic adv1;
  logic adv2;
  logic accept;

  logic s1_valid_q, s1_valid_d;
  logic out_valid_q, out_valid_d;

  always_comb begin
    adv2   = !out_valid_q || out_ready;
    adv1   = !s1_valid_q || adv2;
    accept = in_valid && adv1;
  end

  assign in_ready = adv1;

  // -------------------------------------------------------------------------
  // Stage 1: bit and group generate/propagate
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0]  b_eff;
  logic [WIDTH-1:0]  bit_g;
  logic [WIDTH-1:0]  bit_p;
  logic [3*NG-1:0]   bit_g_lo;   // g of the low 3 bits of each group
  logic [NG-1:0]     grp_g;
  logic [NG-1:0]     grp_p;

  assign b_eff = op ? ~b : b;
  assign bit_g = a & b_eff;
  assign bit_p = a ^ b_eff;

  generate
    for (genvar gi = 0; gi < NG; gi++) begin : g_s1_grp
      logic [3:0] g4;
      logic [3:0] p4;
      assign g4 = bit_g[4*gi +: 4];
      assign p4 = bit_p[4*gi +: 4];
      assign grp_g[gi] = g4[3]
                       | (p4[3] & g4[2])
                       | (p4[3] & p4[2] & g4[1])
                       | (p4[3] & p4[2] & p4[1] & g4[0]);
      assign grp_p[gi] = &p4;
      // The top bit's g only matters through the group G, so it is not
      // carried into stage 2.
      assign bit_g_lo[3*gi +: 3] = g4[2:0];
    end
  endgenerate

  logic [WIDTH-1:0] p_q, p_d;
  logic [3*NG-1:0]  g_lo_q, g_lo_d;
  logic [NG-1:0]    grp_g_q, grp_g_d;
  logic [NG-1:0]    grp_p_q, grp_p_d;
  logic             c0_q, c0_d;

  always_comb begin
    s1_valid_d = s1_valid_q;
    p_d        = p_q;
    g_lo_d     = g_lo_q;
    grp_g_d    = grp_g_q;
    grp_p_d    = grp_p_q;
    c0_d       = c0_q;
    // When stage 1 is free to move it either takes the new beat or empties.
    if (adv1) begin
      s1_valid_d = accept;
    end
    if (accept) begin
      p_d     = bit_p;
      g_lo_d  = bit_g_lo;
      grp_g_d = grp_g;
      grp_p_d = grp_p;
      // Subtract forces the +1 of the two's complement; ci is ignored.
      c0_d    = op | ci;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2: group carry lookahead, bit carries, result and flags
  // -------------------------------------------------------------------------
  logic [NG:0]      grp_c;      // grp_c[k] = carry into group k, grp_c[NG] = co
  logic [WIDTH-1:0] bit_c;      // carry into each bit
  logic [WIDTH-1:0] sum;

  // Each group carry is expanded as a flat sum of products over all lower
  // groups, so no carry ripples from group to group.
  always_comb begin
    logic term;
    grp_c    = '0;
    grp_c[0] = c0_q;
    for (int k = 1; k <= NG; k++) begin
      for (int j = 0; j < k; j++) begin
        term = grp_g_q[j];
        for (int m = j + 1; m < k; m++) begin
          term = term & grp_p_q[m];
        end
        grp_c[k] = grp_c[k] | term;
      end
      term = c0_q;
      for (int m = 0; m < k; m++) begin
        term = term & grp_p_q[m];
      end
      grp_c[k] = grp_c[k] | term;
    end
  end

  generate
    for (genvar gi = 0; gi < NG; gi++) begin : g_s2_grp
      logic [2:0] pp;
      logic [2:0] gg;
      logic       cin;
      assign pp  = p_q[4*gi +: 3];
      assign gg  = g_lo_q[3*gi +: 3];
      assign cin = grp_c[gi];
      assign bit_c[4*gi]   = cin;
      assign bit_c[4*gi+1] = gg[0] | (pp[0] & cin);
      assign bit_c[4*gi+2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & cin);
      assign bit_c[4*gi+3] = gg[2]
                           | (pp[2] & gg[1])
                           | (pp[2] & pp[1] & gg[0])
                           | (pp[2] & pp[1] & pp[0] & cin);
    end
  endgenerate

  assign sum = p_q ^ bit_c;

  logic [WIDTH-1:0] s_q, s_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  always_comb begin
    out_valid_d = out_valid_q;
    s_d         = s_q;
    co_d        = co_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    // While the consumer stalls a valid result, everything here holds.
    if (adv2) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s_d    = sum;
        co_d   = grp_c[NG];
        ovf_d  = bit_c[WIDTH-1] ^ grp_c[NG];
        zero_d = (sum == '0);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      p_q         <= '0;
      g_lo_q      <= '0;
      grp_g_q     <= '0;
      grp_p_q     <= '0;
      c0_q        <= 1'b0;
      out_valid_q <= 1'b0;
      s_q         <= '0;
      co_q        <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      p_q         <= p_d;
      g_lo_q      <= g_lo_d;
      grp_g_q     <= grp_g_d;
      grp_p_q     <= grp_p_d;
      c0_q        <= c0_d;
      out_valid_q <= out_valid_d;
      s_q         <= s_d;
      co_q        <= co_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign co        = co_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// ---------------------------------------------------------------------------
// tb_cla_pipe_addsub
//
// Self-checking bench for cla_pipe_addsub. A 32-bit and an 8-bit instance
// share the handshake and the low operand bits. Results are matched in
// order against an expected queue filled at each accept; directed beats
// carry hand-computed values, random beats use a small arithmetic model.
// ---------------------------------------------------------------------------
module tb_cla_pipe_addsub;

  typedef struct packed {
    logic [31:0] s;
    logic        co;
    logic        ovf;
    logic        zero;
    logic        lat;       // check 2-cycle latency on this beat
    logic [31:0] acc_cyc;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        ci;
  logic        op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] s;
  logic        co;
  logic        ovf;
  logic        zero;

  logic        in_ready8;
  logic        out_valid8;
  logic [7:0]  s8;
  logic        co8;
  logic        ovf8;
  logic        zero8;

  int          n_checks;
  int          n_pass;
  int          n_pop;
  logic [31:0] cyc;
  exp_t        cur_exp;
  exp_t        exp_q[$];
  exp_t        exp8_q[$];

  cla_pipe_addsub #(.WIDTH(32)) u_dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .co        (co),
    .ovf       (ovf),
    .zero      (zero)
  );

  cla_pipe_addsub #(.WIDTH(8)) u_dut8 (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready8),
    .a         (a[7:0]),
    .b         (b[7:0]),
    .ci        (ci),
    .op        (op),
    .out_valid (out_valid8),
    .out_ready (out_ready),
    .s         (s8),
    .co        (co8),
    .ovf       (ovf8),
    .zero      (zero8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
    end else begin
      n_pass++;
    end
  endtask

  function automatic exp_t mk(input logic [31:0] sv, input logic cov, input logic ovfv,
                              input logic zv, input logic lat);
    exp_t r;
    r      = '0;
    r.s    = sv;
    r.co   = cov;
    r.ovf  = ovfv;
    r.zero = zv;
    r.lat  = lat;
    return r;
  endfunction

  // Reference: plain wide addition, overflow from operand/result signs.
  function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv,
                                 input logic civ, input logic opv, input int w);
    logic [63:0] m;
    logic [63:0] aa;
    logic [63:0] bb;
    logic [63:0] sum;
    exp_t        r;
    m   = (64'd1 << w) - 64'd1;
    aa  = {32'd0, av} & m;
    bb  = {32'd0, (opv ? ~bv : bv)} & m;
    sum = aa + bb + (opv ? 64'd1 : {63'd0, civ});
    r      = '0;
    r.s    = sum[31:0] & m[31:0];
    r.co   = sum[w];
    r.zero = (r.s == 32'd0);
    r.ovf  = (aa[w-1] == bb[w-1]) && (sum[w-1] != aa[w-1]);
    return r;
  endfunction

  // One clock cycle: sample handshakes at the falling edge, then return
  // just after the next rising edge, where new inputs are driven.
  task automatic tick(output bit acc, output bit fired);
    exp_t e;
    exp_t e8;
    @(negedge clock);
    cyc++;
    acc   = in_valid && in_ready && !reset;
    fired = out_valid && out_ready && !reset;
    if (acc) begin
      e         = cur_exp;
      e.acc_cyc = cyc;
      exp_q.push_back(e);
    end
    if (in_valid && in_ready8 && !reset) begin
      e8 = model(a, b, ci, op, 8);
      exp8_q.push_back(e8);
    end
    if (fired) begin
      check_eq("out_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        $display("cyc %0d out32 s=%08h co=%0b ovf=%0b zero=%0b", cyc, s, co, ovf, zero);
        check_eq("s", s, e.s);
        check_eq("co", co, e.co);
        check_eq("ovf", ovf, e.ovf);
        check_eq("zero", zero, e.zero);
        if (e.lat) check_eq("latency", cyc - e.acc_cyc, 2);
      end
      n_pop++;
    end
    if (out_valid8 && out_ready && !reset) begin
      check_eq("out8_expected", exp8_q.size() != 0, 1);
      if (exp8_q.size() != 0) begin
        e8 = exp8_q.pop_front();
        check_eq("w8_s", s8, e8.s);
        check_eq("w8_co", co8, e8.co);
        check_eq("w8_ovf", ovf8, e8.ovf);
        check_eq("w8_zero", zero8, e8.zero);
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input int n);
    bit acc;
    bit fired;
    for (int i = 0; i < n; i++) tick(acc, fired);
  endtask

  task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic civ,
                      input logic opv, input exp_t e);
    bit acc;
    bit fired;
    int n;
    in_valid = 1'b1;
    a        = av;
    b        = bv;
    ci       = civ;
    op       = opv;
    cur_exp  = e;
    acc      = 1'b0;
    n        = 0;
    while (!acc && n < 20) begin
      tick(acc, fired);
      n++;
    end
    check_eq("send_accept", acc, 1);
    in_valid = 1'b0;
  endtask

  initial begin
    bit acc;
    bit fired;
    int idx;
    int stall;
    bit stall_done;
    int pops0;
    n_checks  = 0;
    n_pass    = 0;
    n_pop     = 0;
    cyc       = 0;
    cur_exp   = '0;
    reset     = 1'b1;
    in_valid  = 1'b1;
    a         = 32'd123;
    b         = 32'd456;
    ci        = 1'b0;
    op        = 1'b0;
    out_ready = 1'b1;

    // Reset held 2 cycles with in_valid high.
    @(posedge clock);
    #1;
    drain(2);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_s", s, 0);
    check_eq("rst_co", co, 0);
    check_eq("rst_ovf", ovf, 0);
    check_eq("rst_zero", zero, 0);
    check_eq("rst_out_valid8", out_valid8, 0);
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    check_eq("rst_in_ready", in_ready, 1);
    drain(3);
    check_eq("rst_no_result", n_pop, 0);

    // Directed add / subtract corner cases, latency 2 each.
    out_ready = 1'b1;
    send(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, mk(32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1));
    drain(3);
    send(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, mk(32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1));
    drain(3);
    send(32'd5, 32'd7, 1'b1, 1'b1, mk(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1));
    drain(3);
    send(32'h8000_0000, 32'd1, 1'b0, 1'b1, mk(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b1));
    drain(3);
    send(32'd10, 32'd20, 1'b1, 1'b0, mk(32'd31, 1'b0, 1'b0, 1'b0, 1'b1));
    drain(3);
    send(32'd9, 32'd9, 1'b0, 1'b1, mk(32'd0, 1'b1, 1'b0, 1'b1, 1'b1));
    drain(3);
    check_eq("directed_drained", exp_q.size(), 0);

    // Backpressure: 4 beats, consumer stalls 3 cycles after the first result.
    pops0      = n_pop;
    idx        = 0;
    stall      = 0;
    stall_done = 1'b0;
    out_ready  = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (idx < 4) begin
        in_valid = 1'b1;
        a        = 32'(idx + 1);
        b        = 32'd10;
        ci       = 1'b0;
        op       = 1'b0;
        cur_exp  = mk(32'(idx + 11), 1'b0, 1'b0, 1'b0, 1'b0);
      end else begin
        in_valid = 1'b0;
      end
      out_ready = (stall == 0);
      if (stall > 0) begin
        #1;
        check_eq("bp_in_ready", in_ready, 0);
        check_eq("bp_hold_valid", out_valid, 1);
        check_eq("bp_hold_s", s, 32'd12);
      end
      tick(acc, fired);
      if (acc) idx++;
      if (stall > 0) begin
        stall--;
      end else if (fired && !stall_done) begin
        stall      = 3;
        stall_done = 1'b1;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_eq("bp_count", n_pop - pops0, 4);
    check_eq("bp_drained", exp_q.size(), 0);

    // Full throughput: 100 random beats back to back.
    pops0 = n_pop;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      a        = $urandom;
      b        = $urandom;
      ci       = 1'($urandom_range(0, 1));
      op       = 1'($urandom_range(0, 1));
      cur_exp  = model(a, b, ci, op, 32);
      cur_exp.lat = 1'b1;
      tick(acc, fired);
      check_eq("tp_accept", acc, 1);
      if (i >= 2) check_eq("tp_fired", fired, 1);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick(acc, fired);
      check_eq("tp_tail_fired", fired, 1);
    end
    check_eq("tp_count", n_pop - pops0, 100);
    check_eq("tp_drained", exp_q.size(), 0);
    check_eq("tp_drained8", exp8_q.size(), 0);

    // Reset with two beats in flight and the consumer stalled.
    out_ready = 1'b0;
    send(32'd1, 32'd2, 1'b0, 1'b0, mk(32'd3, 1'b0, 1'b0, 1'b0, 1'b0));
    send(32'd5, 32'd6, 1'b0, 1'b0, mk(32'd11, 1'b0, 1'b0, 1'b0, 1'b0));
    reset = 1'b1;
    tick(acc, fired);
    reset = 1'b0;
    exp_q.delete();
    exp8_q.delete();
    check_eq("mid_rst_out_valid", out_valid, 0);
    check_eq("mid_rst_in_ready", in_ready, 1);
    pops0     = n_pop;
    out_ready = 1'b1;
    drain(4);
    check_eq("mid_rst_no_result", n_pop - pops0, 0);
    send(32'd3, 32'd4, 1'b0, 1'b0, mk(32'd7, 1'b0, 1'b0, 1'b0, 1'b1));
    drain(3);
    check_eq("mid_rst_count", n_pop - pops0, 1);
    check_eq("mid_rst_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cla_pipe_addsub.md
# cla_pipe_addsub

Parametrised, two-stage pipelined carry-lookahead adder/subtractor with a valid/ready handshake on both sides. It replaces the single-register clocked CLA, adding a configurable width, a subtract mode, signed-overflow and zero flags, and backpressure. It sits between operand-producing logic and any consumer that may stall, and sustains one operation per cycle.

## Interface
- WIDTH, 32, operand/result width in bits; multiple of 4, minimum 4
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block accepts a beat this cycle (combinational)
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- ci  input  1  carry-in (add mode only)
- op  input  1  0 = add (a+b+ci), 1 = subtract (a+~b+1, ci ignored)
- out_valid  output  1  result beat valid (registered)
- out_ready  input  1  consumer accepts result this cycle
- s  output  WIDTH  sum/difference
- co  output  1  carry out of MSB (subtract: 1 = no borrow)
- ovf  output  1  signed overflow, carry into MSB XOR carry out of MSB
- zero  output  1  s == 0

## Operation
- Datapath built from 4-bit CLA groups: per-bit g = a&b', p = a^b' (b' = op ? ~b : b); group G/P per 4 bits; group carries by lookahead across groups; carry-in c0 = op ? 1 : ci.
- Stage 1 (S1): on accept, register bit p, group G/P, group bit-level g/p needed for sums, and c0; S1 valid bit set.
- Stage 2 (S2): from S1 registers, resolve all group carries, form s, co, ovf, zero; register into output; out_valid set.
- Advance rules (all evaluated in the same cycle):
  - adv2 = !out_valid | out_ready
  - adv1 = !s1_valid | adv2
  - in_ready = adv1
- Accept occurs when in_valid & in_ready; S1 loads new beat, otherwise S1 valid clears when adv1 and no accept.
- S2 loads from S1 when adv2 & s1_valid; out_valid clears when adv2 and S1 empty.
- While out_valid & !out_ready: s, co, ovf, zero, out_valid held stable; S1 holds if full; in_ready = !s1_valid.
- Beats never dropped, duplicated or reordered; max occupancy 2.

## Timing
- Reset (synchronous, wins over all other activity including a concurrent accept): s1_valid=0, out_valid=0, s=0, co=0, ovf=0, zero=0; in_ready=1 in the cycle following reset deassertion.
- Reset mid-operation: any in-flight beats discarded; no out_valid pulse after reset.
- Latency: beat accepted at edge N appears with out_valid=1 after edge N+2, given no stall.
- Throughput: 1 beat/cycle with out_ready held high.
- Simultaneous out_ready and accept with pipeline full: S2 takes S1, S1 takes new beat, same edge.
- out_ready while out_valid=0: no effect.
- Inputs a, b, ci, op sampled only on accept edge; ignored otherwise.
- Wrap-around: results modulo 2^WIDTH; co carries the lost bit.

## Test plan
- Reset/idle: assert reset 2 cycles with in_valid=1 -> out_valid=0, s=0, co=0, ovf=0, zero=0; in_ready=1 after release; no result emerges.
- Add carry/overflow (WIDTH=32): a=32'hFFFF_FFFF, b=1, ci=0, op=0 -> s=0, co=1, zero=1, ovf=0; a=32'h7FFF_FFFF, b=1 -> s=32'h8000_0000, co=0, ovf=1; both at latency 2.
- Subtract: a=5, b=7, op=1, ci=1 -> s=32'hFFFF_FFFE, co=0, ovf=0; a=32'h8000_0000, b=1, op=1 -> s=32'h7FFF_FFFF, co=1, ovf=1.
- Backpressure: stream 4 beats (a=1..4, b=10, op=0) with out_ready low for 3 cycles after first result -> in_ready drops once 2 beats held; s sequence 11,12,13,14 exactly once each, outputs stable during stall.
- Full throughput: 100 random beats back-to-back, out_ready=1, WIDTH=8 and WIDTH=32 builds -> one result per cycle, all match reference model (s, co, ovf, zero).
- Reset mid-flight: 2 beats in pipeline, out_ready=0, assert reset 1 cycle -> out_valid=0 next cycle, neither beat ever emitted; next accepted beat a=3, b=4 -> s=7 at latency 2.
